// File: rtl/pc_pkg.sv
// pc_pkg: shared types, default constants and helpers for the fetch-stage
// program-counter unit. Imported by pc_prio_sel and pc_next_unit.
package pc_pkg;

  // Control states of the PC unit: one boot cycle, normal run, and a
  // state holding a redirect that arrived while fetch was stalled.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Ceiling log2, used for index widths and the STEP alignment width.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_prio_sel.sv
// pc_prio_sel: NSRC-way fixed-priority encoder plus target mux.
// Index 0 has the highest priority. Purely combinational.
module pc_prio_sel
  import pc_pkg::*;
#(
  parameter int NSRC = 3,
  parameter int XLEN = DEFAULT_XLEN,
  parameter int IDXW = 2
) (
  input  logic [NSRC-1:0]      valid,
  input  logic [NSRC*XLEN-1:0] targets,
  output logic                 any_valid,
  output logic [IDXW-1:0]      win_idx,
  output logic [XLEN-1:0]      win_target
);

  // Scan from lowest priority upward so the lowest set index is the last
  // assignment and therefore wins.
  always_comb begin
    any_valid  = 1'b0;
    win_idx    = '0;
    win_target = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (valid[k]) begin
        any_valid  = 1'b1;
        win_idx    = IDXW'(k);
        win_target = targets[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch-stage program counter with sequential step, prioritised
// redirects and buffering of redirects that arrive during a stall.
// Optional feature macro: PC_ALIGN_CHECK_EN flags redirect targets that are
// not STEP-aligned on misalign_o; without it misalign_o is tied low.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              STEP     = 4,
  parameter int              NSRC     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic [NSRC-1:0]      redir_valid_i,
  input  logic [NSRC*XLEN-1:0] redir_target_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [XLEN-1:0]      pc_plus_o,
  output logic                 pc_valid_o,
  output logic                 redir_taken_o,
  output logic                 misalign_o
);

  localparam int IDXW = (NSRC > 1) ? clog2(NSRC) : 1;

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic [IDXW-1:0] pend_idx_q, pend_idx_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  logic            live_any;
  logic [IDXW-1:0] live_idx;
  logic [XLEN-1:0] live_tgt;
  logic            live_beats_pend;

  pc_prio_sel #(
    .NSRC (NSRC),
    .XLEN (XLEN),
    .IDXW (IDXW)
  ) u_live_sel (
    .valid      (redir_valid_i),
    .targets    (redir_target_i),
    .any_valid  (live_any),
    .win_idx    (live_idx),
    .win_target (live_tgt)
  );

  // A live request replaces the buffered one when it is at least as urgent;
  // on an equal index the newer target is the one that counts.
  assign live_beats_pend = live_any && (live_idx <= pend_idx_q);

  // Next-state and next-PC selection; taken defaults low so it pulses once.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    taken_d    = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (live_any) begin
          if (!stall_i) begin
            pc_d    = live_tgt;
            taken_d = 1'b1;
          end else begin
            pend_idx_d = live_idx;
            pend_tgt_d = live_tgt;
            state_d    = PEND;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + XLEN'(STEP);
        end
      end
      PEND: begin
        if (stall_i) begin
          if (live_beats_pend) begin
            pend_idx_d = live_idx;
            pend_tgt_d = live_tgt;
          end
        end else begin
          pc_d       = live_beats_pend ? live_tgt : pend_tgt_q;
          taken_d    = 1'b1;
          state_d    = RUN;
          pend_idx_d = '0;
          pend_tgt_d = '0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and pending-buffer registers; reset discards the buffer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      taken_q    <= taken_d;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus_o     = pc_q + XLEN'(STEP);
  assign pc_valid_o    = valid_q;
  assign redir_taken_o = taken_q;

`ifdef PC_ALIGN_CHECK_EN
  localparam int              ALIGNW     = clog2(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGNW) - 64'd1);

  logic mis_q;

  // Flag a redirect load whose low target bits are nonzero; increments clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= taken_d & (|(pc_d & ALIGN_MASK));
    end
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed bench for pc_next_unit with a cycle-level
// reference model and a per-cycle compare process.
module tb_pc_next_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic [2:0]  redir_valid_i = '0;
  logic [95:0] redir_target_i = '0;
  logic [31:0] pc_o, pc_plus_o;
  logic        pc_valid_o, redir_taken_o, misalign_o;

  logic [31:0] tgt_in [3];

  int check_count = 0;
  int pass_count  = 0;
  bit check_en    = 1'b0;

  logic [31:0] m_pc       = RST_PC;
  logic        m_valid    = 1'b0;
  logic        m_taken    = 1'b0;
  logic        m_mis      = 1'b0;
  bit          m_booted   = 1'b0;
  int          m_pend     = -1;
  logic [31:0] m_pend_tgt = '0;

  pc_next_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .STEP     (4),
    .NSRC     (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .pc_o           (pc_o),
    .pc_plus_o      (pc_plus_o),
    .pc_valid_o     (pc_valid_o),
    .redir_taken_o  (redir_taken_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    else
      pass_count++;
  endtask

  // Load a redirect target into the model, recording misalignment if enabled.
  task automatic modelLoad(input logic [31:0] t);
    m_pc    = t;
    m_taken = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
    m_mis = (t % 4) != 0;
`endif
  endtask

  // Reference model: the PC behaviour expressed as "what happens this cycle".
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_taken = 0; m_mis = 0;
      m_booted = 0; m_pend = -1; m_pend_tgt = '0;
    end else begin
      int win;
      win = -1;
      for (int k = 2; k >= 0; k--) if (redir_valid_i[k]) win = k;
      m_taken = 0;
      m_mis   = 0;
      if (!m_booted) begin
        m_booted = 1;
        m_valid  = 1;
      end else if (m_pend < 0) begin
        if (win >= 0 && !stall_i) modelLoad(tgt_in[win]);
        else if (win >= 0) begin m_pend = win; m_pend_tgt = tgt_in[win]; end
        else if (!stall_i) m_pc = m_pc + 32'd4;
      end else begin
        if (win >= 0 && win <= m_pend) begin m_pend = win; m_pend_tgt = tgt_in[win]; end
        if (!stall_i) begin modelLoad(m_pend_tgt); m_pend = -1; end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("pc", pc_o, m_pc);
      checkOutput("pc_plus", pc_plus_o, m_pc + 32'd4);
      checkOutput("pc_valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
      checkOutput("redir_taken", {31'd0, redir_taken_o}, {31'd0, m_taken});
      checkOutput("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    end
  end

  task automatic applyStimulus(input logic st, input logic [2:0] v,
                               input logic [31:0] t0, input logic [31:0] t1,
                               input logic [31:0] t2);
    stall_i        = st;
    redir_valid_i  = v;
    tgt_in[0]      = t0;
    tgt_in[1]      = t1;
    tgt_in[2]      = t2;
    redir_target_i = {t2, t1, t0};
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic st);
    applyStimulus(st, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_mis;
    tgt_in[0] = '0; tgt_in[1] = '0; tgt_in[2] = '0;
    rst      = 1'b1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("lit_reset_pc", pc_o, 32'h100);
    checkOutput("lit_reset_valid", {31'd0, pc_valid_o}, 32'd0);
    rst = 1'b0;

    idle(1'b0);
    checkOutput("lit_boot_pc", pc_o, 32'h100);
    checkOutput("lit_boot_valid", {31'd0, pc_valid_o}, 32'd1);
    idle(1'b0);
    checkOutput("lit_step1", pc_o, 32'h104);
    idle(1'b0);
    checkOutput("lit_step2", pc_o, 32'h108);

    applyStimulus(1'b0, 3'b001, 32'h200, 32'h0, 32'h0);
    checkOutput("lit_redir_200", pc_o, 32'h200);
    applyStimulus(1'b0, 3'b110, 32'h0, 32'h400, 32'h800);
    checkOutput("lit_prio_pc", pc_o, 32'h400);
    checkOutput("lit_prio_taken", {31'd0, redir_taken_o}, 32'd1);
    idle(1'b0);
    checkOutput("lit_after_taken", {31'd0, redir_taken_o}, 32'd0);
    checkOutput("lit_after_pc", pc_o, 32'h404);

    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h800);
    idle(1'b1);
    applyStimulus(1'b1, 3'b001, 32'h10, 32'h0, 32'h0);
    idle(1'b1);
    checkOutput("lit_stall_hold", pc_o, 32'h404);
    idle(1'b0);
    checkOutput("lit_pend_override", pc_o, 32'h10);
    checkOutput("lit_pend_taken", {31'd0, redir_taken_o}, 32'd1);

    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h800);
    repeat (3) idle(1'b1);
    idle(1'b0);
    checkOutput("lit_pend_only", pc_o, 32'h800);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h900);
    idle(1'b0);
    checkOutput("lit_pend_drop", pc_o, 32'h300);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'h500, 32'h0);
    checkOutput("lit_equal_live_wins", pc_o, 32'h500);

    applyStimulus(1'b0, 3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0);
    checkOutput("lit_top_plus", pc_plus_o, 32'h0);
    idle(1'b0);
    checkOutput("lit_wrap_pc", pc_o, 32'h0);
    checkOutput("lit_wrap_plus", pc_plus_o, 32'h4);

    applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    exp_mis = 32'd1;
`else
    exp_mis = 32'd0;
`endif
    checkOutput("lit_mis_pc", pc_o, 32'h102);
    checkOutput("lit_mis_flag", {31'd0, misalign_o}, exp_mis);
    idle(1'b0);
    checkOutput("lit_mis_clear", {31'd0, misalign_o}, 32'd0);

    applyStimulus(1'b1, 3'b010, 32'h0, 32'h700, 32'h0);
    #1 rst = 1'b1;
    #1;
    checkOutput("lit_async_pc", pc_o, 32'h100);
    checkOutput("lit_async_valid", {31'd0, pc_valid_o}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(1'b0);
    checkOutput("lit_reboot_pc", pc_o, 32'h100);
    idle(1'b0);
    checkOutput("lit_buffer_gone", pc_o, 32'h104);
    idle(1'b1);
    idle(1'b0);
    checkOutput("lit_no_stale", pc_o, 32'h108);
    idle(1'b0);

    check_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
